// File: rtl/featuremap_pkg.sv
// featuremap_pkg: shared FP32 field layout, constants and FSM encoding for the
// channel-reduction stage (featuremap_reduce and its fp32_adder).
package featuremap_pkg;

    localparam int unsigned EXP_W       = 8;
    localparam int unsigned MAN_W       = 23;
    localparam int unsigned EXP_BIAS    = 127;
    localparam int unsigned LEAKY_SHIFT = 3;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    // FP32 word split into its fields
    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] expo;
        logic [MAN_W-1:0] man;
    } fp32_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/featuremap_reduce_if.sv
// featuremap_reduce_if: vector-in / pixel-out bus of the channel-reduction stage.
//   data_in   packed NUM_CH x FP32 vector, ch[i] = data_in[32*i+31 : 32*i]
//   valid_in  data_in valid
//   in_ready  stage can accept a vector
//   data_out  FP32 result, held until the next result
//   valid_out one-cycle pulse marking a new data_out
// master = producer/consumer side, slave = featuremap_reduce.
interface featuremap_reduce_if #(
    parameter int unsigned NUM_CH     = 16,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [NUM_CH*DATA_WIDTH-1:0] data_in;
    logic                         valid_in;
    logic                         in_ready;
    logic [DATA_WIDTH-1:0]        data_out;
    logic                         valid_out;

    modport master (
        output data_in, valid_in,
        input  in_ready, data_out, valid_out
    );

    modport slave (
        input  data_in, valid_in,
        output in_ready, data_out, valid_out
    );
endinterface

// File: rtl/featuremap_reduce_fp32_adder.sv
// fp32_adder: combinational FP32 add, round-to-nearest-even.
//   a, b  FP32 operands; exp==0 (zero/denormal) is read as +0
//   y     a + b; underflow flushes to +0, overflow gives signed infinity,
//         exact cancellation gives +0
module fp32_adder
    import featuremap_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    // hidden bit + mantissa + guard/round/sticky
    localparam int unsigned EXT_W = MAN_W + 4;
    localparam int unsigned LZ_W  = $clog2(EXT_W);
    localparam int unsigned RND_W = MAN_W + 2;

    fp32_t                   fa, fb, big, sml;
    logic                    a_zero, b_zero, a_big, sticky, rnd_up;
    logic [EXP_W-1:0]        ediff;
    logic [EXT_W-1:0]        big_ext, sml_ext, sml_sh, mask, norm;
    logic [EXT_W:0]          sum;
    logic [LZ_W-1:0]         lz;
    logic signed [9:0]       exp_n, exp_r;
    logic [RND_W-1:0]        rnd;
    logic [MAN_W-1:0]        man_r;

    always_comb begin
        fa      = fp32_t'(a);
        fb      = fp32_t'(b);
        a_zero  = (fa.expo == '0);
        b_zero  = (fb.expo == '0);
        a_big   = {fa.expo, fa.man} >= {fb.expo, fb.man};
        big     = a_big ? fa : fb;
        sml     = a_big ? fb : fa;
        ediff   = big.expo - sml.expo;
        big_ext = {1'b1, big.man, 3'b000};
        sml_ext = {1'b1, sml.man, 3'b000};

        // align the smaller operand, folding shifted-out bits into sticky
        mask   = '0;
        sml_sh = '0;
        sticky = 1'b0;
        if (ediff >= 8'(EXT_W)) begin
            sticky = 1'b1;
        end else begin
            sml_sh = sml_ext >> ediff;
            mask   = (EXT_W'(1) << ediff) - EXT_W'(1);
            sticky = |(sml_ext & mask);
        end
        sml_sh[0] = sml_sh[0] | sticky;

        if (big.sign ^ sml.sign)
            sum = {1'b0, big_ext} - {1'b0, sml_sh};
        else
            sum = {1'b0, big_ext} + {1'b0, sml_sh};

        // leading-zero count: last hit wins, i.e. the highest set bit
        lz = '0;
        for (int i = 0; i < EXT_W; i++) begin
            if (sum[i]) lz = LZ_W'(EXT_W - 1 - i);
        end

        if (sum[EXT_W]) begin
            norm  = {sum[EXT_W:2], sum[1] | sum[0]};
            exp_n = $signed({2'b00, big.expo}) + 10'sd1;
        end else begin
            norm  = sum[EXT_W-1:0] << lz;
            exp_n = $signed({2'b00, big.expo}) - $signed({5'b00000, lz});
        end

        rnd_up = norm[2] & (norm[3] | norm[1] | norm[0]);
        rnd    = {1'b0, norm[EXT_W-1:3]} + RND_W'(rnd_up);
        exp_r  = exp_n + $signed({9'b0, rnd[RND_W-1]});
        man_r  = rnd[RND_W-1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];

        y = {big.sign, exp_r[EXP_W-1:0], man_r};
        if (a_zero && b_zero)
            y = FP_ZERO;
        else if (a_zero)
            y = b;
        else if (b_zero)
            y = a;
        else if (sum == '0)
            y = FP_ZERO;
        else if (exp_r <= 10'sd0)
            y = FP_ZERO;
        else if (exp_r >= 10'sd255)
            y = {big.sign, 8'hff, 23'h0};
    end

endmodule

// File: rtl/featuremap_reduce.sv
// featuremap_reduce: serial channel reduction of one conv output pixel.
// Captures a NUM_CH x FP32 vector, accumulates BIAS+ch0+ch1+... in order with
// one fp32_adder, applies the activation and pulses valid_out.
//   Clk  clock, rising edge
//   Rst  asynchronous active-low reset
//   bus  featuremap_reduce_if.slave (data_in/valid_in/in_ready/data_out/valid_out)
// Optional macro FEATUREMAP_LEAKY_RELU_EN: leaky ReLU (negative x scaled by 1/8);
// undefined gives a linear output.
module featuremap_reduce
    import featuremap_pkg::*;
#(
    parameter int unsigned NUM_CH     = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [31:0] BIAS       = 32'h0
) (
    input  logic              Clk,
    input  logic              Rst,
    featuremap_reduce_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_CH) + 1;
    localparam int unsigned VEC_W = NUM_CH * DATA_WIDTH;

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        idx;
    logic [VEC_W-1:0]        vec_r;
    logic [DATA_WIDTH-1:0]   acc, sum_c, act_c, data_out_r;
    logic                    valid_out_r;
    logic                    in_ready, accept_c, acc_en_c, out_en_c;

    // state register
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // next-state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.valid_in) state_nxt = ST_ACC;
            ST_ACC:  if (idx == IDX_W'(NUM_CH - 1)) state_nxt = ST_OUT;
            ST_OUT:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // state decode
    always_comb begin
        in_ready = 1'b0;
        acc_en_c = 1'b0;
        out_en_c = 1'b0;
        case (state)
            ST_IDLE: in_ready = 1'b1;
            ST_ACC:  acc_en_c = 1'b1;
            ST_OUT:  out_en_c = 1'b1;
            default: in_ready = 1'b0;
        endcase
        accept_c = in_ready & bus.valid_in;
    end

    // the head channel always sits in the low word; vec_r shifts down per add
    fp32_adder u_fp32_adder (
        .a (acc),
        .b (vec_r[DATA_WIDTH-1:0]),
        .y (sum_c)
    );

`ifdef FEATUREMAP_LEAKY_RELU_EN
    // negative: exponent-3 (exact x/8); too small to scale flushes to +0
    always_comb begin
        act_c = acc;
        if (acc[31]) begin
            if (acc[30:23] <= 8'(LEAKY_SHIFT))
                act_c = FP_ZERO;
            else
                act_c = {1'b1, acc[30:23] - 8'(LEAKY_SHIFT), acc[22:0]};
        end
    end
`else
    assign act_c = acc;
`endif

    // datapath: capture, accumulate, emit
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            vec_r       <= '0;
            acc         <= '0;
            idx         <= '0;
            data_out_r  <= '0;
            valid_out_r <= 1'b0;
        end else begin
            valid_out_r <= 1'b0;
            if (accept_c) begin
                vec_r <= bus.data_in;
                acc   <= BIAS;
                idx   <= '0;
            end
            if (acc_en_c) begin
                acc   <= sum_c;
                vec_r <= vec_r >> DATA_WIDTH;
                idx   <= idx + IDX_W'(1);
            end
            if (out_en_c) begin
                data_out_r  <= act_c;
                valid_out_r <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.data_out  = data_out_r;
    assign bus.valid_out = valid_out_r;

endmodule

// File: tb/tb_featuremap_reduce.sv
// tb_featuremap_reduce: scoreboard bench for featuremap_reduce.
// Main instance: NUM_CH=16, BIAS=0. Second instance: NUM_CH=2, BIAS=1.0.
// Expected pixels come from integer channel sums converted to FP32 here.
module tb_featuremap_reduce;

    localparam int unsigned NUM_CH = 16;
    localparam int unsigned VEC_W  = NUM_CH * 32;

    logic Clk;
    logic Rst;
    int   cyc;
    int   acc_cyc;
    int   last_lat;
    int   n_checks;
    int   n_errors;
    logic prev_vo;
    logic [31:0] sb[$];

    featuremap_reduce_if #(.NUM_CH(NUM_CH), .DATA_WIDTH(32)) bus1 ();
    featuremap_reduce_if #(.NUM_CH(2),      .DATA_WIDTH(32)) bus2 ();

    featuremap_reduce #(.NUM_CH(NUM_CH), .DATA_WIDTH(32), .BIAS(32'h0)) u_dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus1)
    );

    featuremap_reduce #(.NUM_CH(2), .DATA_WIDTH(32), .BIAS(32'h3f800000)) u_dut2 (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // v * 2^-sh as FP32, for |v| < 2^24
    function automatic logic [31:0] int_to_fp(input int v, input int sh);
        logic [31:0] mag;
        logic [31:0] m;
        int p;
        if (v == 0) return 32'h0;
        mag = (v < 0) ? 32'(-v) : 32'(v);
        p = 0;
        for (int i = 0; i < 24; i++) if (mag[i]) p = i;
        m = mag << (23 - p);
        return {(v < 0), 8'(127 + p - sh), m[22:0]};
    endfunction

    function automatic logic [31:0] model_px(input int s);
`ifdef FEATUREMAP_LEAKY_RELU_EN
        if (s < 0) return int_to_fp(s, 3);
`endif
        return int_to_fp(s, 0);
    endfunction

    // output monitor: pop and compare every pulse, check pulse width
    always @(negedge Clk) begin
        if (bus1.valid_out) begin
            check_eq("vo_width", 32'(prev_vo), 32'h0);
            last_lat = cyc - acc_cyc;
            if (sb.size() == 0) begin
                check_eq("unexpected_out", bus1.data_out, 32'hxxxxxxxx);
            end else begin
                check_eq("data_out", bus1.data_out, sb.pop_front());
            end
        end
        prev_vo = bus1.valid_out;
    end

    task automatic send_vec(input logic [VEC_W-1:0] v, input logic [31:0] exp);
        int n = 0;
        @(negedge Clk);
        while (!bus1.in_ready && n < 50) begin
            @(negedge Clk);
            n++;
        end
        check_eq("ready_wait", 32'(bus1.in_ready), 32'h1);
        bus1.data_in  = v;
        bus1.valid_in = 1'b1;
        sb.push_back(exp);
        @(posedge Clk);
        #1;
        acc_cyc = cyc;
        bus1.valid_in = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge Clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            check_eq("drain_timeout", 32'(sb.size()), 32'h0);
            sb.delete();
        end
    endtask

    task automatic rand_vec(output logic [VEC_W-1:0] v, output int s);
        int e;
        s = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            e = int'($urandom_range(0, 40)) - 20;
            s += e;
            v[32*i +: 32] = int_to_fp(e, 0);
        end
    endtask

    initial begin
        logic [VEC_W-1:0] v;
        int s;
        int prev_acc;
        int n_acc;
        int t0;
        int n;

        cyc = 0; acc_cyc = 0; last_lat = 0; prev_vo = 1'b0;
        n_checks = 0; n_errors = 0;
        bus1.data_in = '0; bus1.valid_in = 1'b0;
        bus2.data_in = '0; bus2.valid_in = 1'b0;
        Rst = 1'b0;
        #3;
        check_eq("rst_in_ready",  32'(bus1.in_ready),  32'h1);
        check_eq("rst_valid_out", 32'(bus1.valid_out), 32'h0);
        check_eq("rst_data_out",  bus1.data_out,       32'h0);
        repeat (3) @(negedge Clk);
        Rst = 1'b1;

        // 1: all ones -> 16.0, latency NUM_CH+1
        for (int i = 0; i < NUM_CH; i++) v[32*i +: 32] = 32'h3f800000;
        send_vec(v, 32'h41800000);
        wait_drain(60);
        check_eq("latency", 32'(last_lat), 32'(NUM_CH + 1));
        @(negedge Clk);
        check_eq("vo_one_cycle", 32'(bus1.valid_out), 32'h0);
        check_eq("data_hold", bus1.data_out, 32'h41800000);

        // 3: all -1
        for (int i = 0; i < NUM_CH; i++) v[32*i +: 32] = 32'hbf800000;
`ifdef FEATUREMAP_LEAKY_RELU_EN
        send_vec(v, 32'hc0000000);
`else
        send_vec(v, 32'hc1800000);
`endif
        wait_drain(60);

        // 6: denormal input flushed
        v = '0;
        v[31:0] = 32'h00000001;
        send_vec(v, 32'h0);
        wait_drain(60);

        // exact cancellation -> +0
        v = '0;
        v[31:0]  = 32'h40a00000;
        v[63:32] = 32'hc0a00000;
        send_vec(v, 32'h0);
        wait_drain(60);

        // overflow -> +inf
        for (int i = 0; i < NUM_CH; i++) v[32*i +: 32] = 32'h7f7fffff;
        send_vec(v, 32'h7f800000);
        wait_drain(60);

        // random integer vectors
        for (int k = 0; k < 4; k++) begin
            rand_vec(v, s);
            send_vec(v, model_px(s));
            wait_drain(60);
        end

        // 4: valid_in held high with new data every cycle
        n_acc = 0;
        prev_acc = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge Clk);
            rand_vec(v, s);
            bus1.data_in  = v;
            bus1.valid_in = 1'b1;
            if (bus1.in_ready) begin
                sb.push_back(model_px(s));
                if (n_acc > 0) check_eq("accept_gap", 32'(cyc - prev_acc), 32'(NUM_CH + 2));
                prev_acc = cyc;
                n_acc++;
            end
        end
        @(negedge Clk);
        bus1.valid_in = 1'b0;
        check_eq("stream_accepts", 32'(n_acc), 32'(100 / (NUM_CH + 2) + 1));
        wait_drain(60);

        // 5: reset in the middle of accumulation
        for (int i = 0; i < NUM_CH; i++) v[32*i +: 32] = 32'h3f800000;
        send_vec(v, 32'h41800000);
        repeat (5) @(negedge Clk);
        Rst = 1'b0;
        sb.delete();
        #1;
        check_eq("abort_in_ready",  32'(bus1.in_ready),  32'h1);
        check_eq("abort_valid_out", 32'(bus1.valid_out), 32'h0);
        check_eq("abort_data_out",  bus1.data_out,       32'h0);
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        repeat (NUM_CH + 4) @(negedge Clk);
        check_eq("abort_data_hold", bus1.data_out, 32'h0);
        send_vec(v, 32'h41800000);
        wait_drain(60);

        // 2: NUM_CH=2 with BIAS=1.0: 1 + 2 - 2 = 1
        @(negedge Clk);
        bus2.data_in  = {32'hc0000000, 32'h40000000};
        bus2.valid_in = 1'b1;
        @(posedge Clk);
        #1;
        t0 = cyc;
        bus2.valid_in = 1'b0;
        n = 0;
        @(negedge Clk);
        while (!bus2.valid_out && n < 20) begin
            @(negedge Clk);
            n++;
        end
        check_eq("b2_valid", 32'(bus2.valid_out), 32'h1);
        check_eq("b2_data", bus2.data_out, 32'h3f800000);
        check_eq("b2_latency", 32'(cyc - t0), 32'h3);

        repeat (2) @(negedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
